wm8731_i2c_writer: RTL and testbench

//  I2C master write engine for the WM8731 control port. Takes one 16-bit word
//  ({reg_addr[6:0], reg_data[8:0]}) from the configuration sequencer upstream.

---
 rtl/wm8731_i2c_writer_if.sv | 24 ++
 rtl/wm8731_i2c_writer.sv | 194 +++++++++++++++++++
 tb/tb_wm8731_i2c_writer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/wm8731_i2c_writer_if.sv
// Handshake bundle between the WM8731 configuration sequencer and the I2C write engine.
interface wm8731_i2c_writer_if;
    logic        start;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [2:0]  ack_status;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  ack_status
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output ack_status
    );
endinterface

// File: rtl/wm8731_i2c_writer.sv
// WM8731 control-port I2C writer: one frame of {DEV_ADDR,W}, word[15:8], word[7:0].
// Optional macro WM8731_NACK_ABORT_EN: a NACK skips the remaining bytes and goes straight to STOP.
module wm8731_i2c_writer #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic               clk,
    input  logic               reset,
    wm8731_i2c_writer_if.slave ctrl,
    output logic               SCLK,
    inout  wire                SDIN
);
    localparam int QW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [QW-1:0] qcnt_reg, qcnt_next;
    logic [1:0]    quarter_reg, quarter_next;
    logic [4:0]    bitcnt_reg, bitcnt_next;
    logic [23:0]   shift_reg, shift_next;
    logic [2:0]    ack_reg, ack_next;
    logic          scl_reg, scl_next;
    logic          sda_low_reg, sda_low_next;

    logic          tick;
    logic          sda_in;
    logic [1:0]    byte_idx;
    logic [1:0]    ack_pos;
    logic          last_data_bit;

    // Bus levels for a given position in the frame: {scl, sda_low}
    function automatic logic [1:0] pin_levels(input state_t st, input logic [1:0] q, input logic bit_value);
        logic scl;
        logic sda_low;
        scl     = 1'b1;
        sda_low = 1'b0;
        case (st)
            ST_START: begin
                scl     = (q < 2'd2);
                sda_low = (q != 2'd0);
            end
            ST_BIT: begin
                scl     = (q >= 2'd2);
                sda_low = ~bit_value;
            end
            ST_ACK: begin
                scl     = (q >= 2'd2);
                sda_low = 1'b0;
            end
            ST_STOP: begin
                scl     = (q != 2'd0);
                sda_low = (q < 2'd2);
            end
            default: begin
                scl     = 1'b1;
                sda_low = 1'b0;
            end
        endcase
        return {scl, sda_low};
    endfunction

    assign sda_in = SDIN;
    assign tick   = (state_reg != ST_IDLE) && (state_reg != ST_DONE) &&
                    (qcnt_reg == QW'(CLK_DIV - 1));

    always_comb begin
        if (bitcnt_reg < 5'd9) begin
            byte_idx = 2'd0;
        end else if (bitcnt_reg < 5'd18) begin
            byte_idx = 2'd1;
        end else begin
            byte_idx = 2'd2;
        end
    end

    assign ack_pos       = 2'd2 - byte_idx;
    assign last_data_bit = (bitcnt_reg == 5'd7) || (bitcnt_reg == 5'd16) || (bitcnt_reg == 5'd25);

    always_comb begin
        state_next   = state_reg;
        qcnt_next    = qcnt_reg;
        quarter_next = quarter_reg;
        bitcnt_next  = bitcnt_reg;
        shift_next   = shift_reg;
        ack_next     = ack_reg;

        case (state_reg)
            ST_IDLE: begin
                qcnt_next    = '0;
                quarter_next = 2'd0;
                bitcnt_next  = 5'd0;
                if (ctrl.start) begin
                    shift_next = {DEV_ADDR, 1'b0, ctrl.data_in};
                    ack_next   = 3'b000;
                    state_next = ST_START;
                end
            end
            ST_DONE: begin
                qcnt_next  = '0;
                state_next = ST_IDLE;
            end
            default: begin
                qcnt_next = tick ? '0 : qcnt_reg + QW'(1);
                if (tick) begin
                    quarter_next = quarter_reg + 2'd1;
                    case (state_reg)
                        ST_START: begin
                            if (quarter_reg == 2'd3) begin
                                state_next = ST_BIT;
                            end
                        end
                        ST_BIT: begin
                            if (quarter_reg == 2'd3) begin
                                shift_next  = {shift_reg[22:0], 1'b0};
                                bitcnt_next = bitcnt_reg + 5'd1;
                                if (last_data_bit) begin
                                    state_next = ST_ACK;
                                end
                            end
                        end
                        ST_ACK: begin
                            // Sample in the middle of the SCL-high window
                            if (quarter_reg == 2'd2) begin
                                ack_next[ack_pos] = ~sda_in;
                            end
                            if (quarter_reg == 2'd3) begin
                                if (bitcnt_reg == 5'd26) begin
                                    state_next = ST_STOP;
                                end else begin
                                    bitcnt_next = bitcnt_reg + 5'd1;
`ifdef WM8731_NACK_ABORT_EN
                                    state_next  = ack_reg[ack_pos] ? ST_BIT : ST_STOP;
`else
                                    state_next  = ST_BIT;
`endif
                                end
                            end
                        end
                        ST_STOP: begin
                            if (quarter_reg == 2'd3) begin
                                state_next = ST_DONE;
                            end
                        end
                        default: begin
                            state_next = ST_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    // Pins are decoded from the next position and registered, so they are glitch-free and not delayed
    always_comb begin
        {scl_next, sda_low_next} = pin_levels(state_next, quarter_next, shift_next[23]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            qcnt_reg    <= '0;
            quarter_reg <= 2'd0;
            bitcnt_reg  <= 5'd0;
            shift_reg   <= 24'd0;
            ack_reg     <= 3'b000;
            scl_reg     <= 1'b1;
            sda_low_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            qcnt_reg    <= qcnt_next;
            quarter_reg <= quarter_next;
            bitcnt_reg  <= bitcnt_next;
            shift_reg   <= shift_next;
            ack_reg     <= ack_next;
            scl_reg     <= scl_next;
            sda_low_reg <= sda_low_next;
        end
    end

    assign ctrl.busy       = (state_reg != ST_IDLE);
    assign ctrl.done       = (state_reg == ST_DONE);
    assign ctrl.ack_status = ack_reg;

    assign SCLK = scl_reg;
    assign SDIN = sda_low_reg ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_wm8731_i2c_writer.sv
// Bench for wm8731_i2c_writer: bus-level frame decoder, ACKing slave model and protocol checker.
module tb_wm8731_i2c_writer;
    localparam int CLK_DIV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic sclk;
    wire  sdin_bus;
    logic slave_low = 1'b0;

    wm8731_i2c_writer_if ctrl ();

    pullup pu_sda (sdin_bus);
    assign sdin_bus = slave_low ? 1'b0 : 1'bz;

    wm8731_i2c_writer #(
        .CLK_DIV  (CLK_DIV),
        .DEV_ADDR (7'h1A)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl),
        .SCLK  (sclk),
        .SDIN  (sdin_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor state
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        in_frame = 1'b0;
    int          rises = 0;
    logic [26:0] bits = '0;
    logic [26:0] frame_bits = '0;
    int          frame_pulses = 0;
    int          starts = 0;
    int          stops = 0;
    int          violations = 0;
    int          done_count = 0;
    logic [2:0]  ack_en = 3'b111;

    always @(negedge clk) begin
        if (!reset) begin
            slave_low <= 1'b0;
            in_frame  <= 1'b0;
        end else begin
            if (ctrl.done) done_count <= done_count + 1;
            if (prev_scl && sclk && (sdin_bus !== prev_sda)) begin
                if (sdin_bus === 1'b0) begin
                    starts    <= starts + 1;
                    in_frame  <= 1'b1;
                    rises     <= 0;
                    bits      <= '0;
                    slave_low <= 1'b0;
                end else begin
                    stops        <= stops + 1;
                    in_frame     <= 1'b0;
                    frame_bits   <= bits;
                    frame_pulses <= rises - 1;   // last rise belongs to STOP
                end
            end else if (!prev_scl && sclk) begin
                if (sdin_bus !== prev_sda) violations <= violations + 1;
                if (in_frame) begin
                    if (rises < 27) bits[26 - rises] <= sdin_bus;
                    rises <= rises + 1;
                end
            end else if (prev_scl && !sclk && in_frame) begin
                slave_low <= (rises % 9 == 8) && (rises <= 26) && ack_en[2 - rises / 9];
            end
        end
        prev_scl <= sclk;
        prev_sda <= sdin_bus;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic [15:0] d, input logic [2:0] acks,
                           input int inject_at);
        logic [7:0]  bytes [3];
        logic [26:0] exp_bits;
        logic [2:0]  exp_ack;
        int          n, s0, p0, d0, v0, c0, elapsed;
        logic        got;

        bytes[0] = 8'h34;
        bytes[1] = d[15:8];
        bytes[2] = d[7:0];
        n = 3;
`ifdef WM8731_NACK_ABORT_EN
        for (int k = 0; k < 3 && n == 3; k++) begin
            if (!acks[2 - k]) n = k + 1;
        end
`endif
        exp_bits = '0;
        exp_ack  = 3'b000;
        for (int k = 0; k < n; k++) begin
            exp_bits[26 - 9 * k -: 9] = {bytes[k], ~acks[2 - k]};
            exp_ack[2 - k]            = acks[2 - k];
        end

        ack_en = acks;
        s0 = starts; p0 = stops; d0 = done_count; v0 = violations;
        @(negedge clk);
        ctrl.data_in = d;
        ctrl.start   = 1'b1;
        c0 = cyc;
        got = 1'b0;
        elapsed = 0;
        for (int k = 1; k <= 2000 && !got; k++) begin
            @(negedge clk);
            ctrl.start = (k == inject_at);
            if (k == inject_at) ctrl.data_in = ~d;
            if (ctrl.done) begin
                got = 1'b1;
                elapsed = cyc - c0;
            end
        end
        ctrl.start = 1'b0;
        check($sformatf("%s done_seen", tag), 32'(got), 32'd1);
        check($sformatf("%s done_latency", tag), elapsed, (8 + 36 * n) * CLK_DIV + 1);
        @(negedge clk);
        check($sformatf("%s busy_after_done", tag), 32'(ctrl.busy), 32'd0);
        repeat (20) @(negedge clk);
        check($sformatf("%s ack_status", tag), 32'(ctrl.ack_status), 32'(exp_ack));
        check($sformatf("%s busy_idle", tag), 32'(ctrl.busy), 32'd0);
        check($sformatf("%s done_count", tag), done_count - d0, 32'd1);
        check($sformatf("%s start_conds", tag), starts - s0, 32'd1);
        check($sformatf("%s stop_conds", tag), stops - p0, 32'd1);
        check($sformatf("%s scl_pulses", tag), frame_pulses, 9 * n);
        check($sformatf("%s frame_bits", tag), 32'(frame_bits), 32'(exp_bits));
        check($sformatf("%s sda_vs_scl", tag), violations - v0, 32'd0);
        $display("txn %s data=%04h acks=%03b pulses=%0d ack_status=%03b latency=%0d",
                 tag, d, acks, frame_pulses, ctrl.ack_status, elapsed);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        ctrl.start   = 1'b0;
        ctrl.data_in = 16'h0000;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(ctrl.busy), 32'd0);
        check("reset done", 32'(ctrl.done), 32'd0);
        check("reset sclk", 32'(sclk), 32'd1);
        check("reset sdin", 32'(sdin_bus), 32'd1);
        check("reset ack_status", 32'(ctrl.ack_status), 32'd0);
        $display("txn reset busy=%0b done=%0b sclk=%0b sdin=%0b", ctrl.busy, ctrl.done, sclk, sdin_bus);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_txn("ack_all", 16'h1201, 3'b111, 0);
        run_txn("nack_hi", 16'h0460, 3'b101, 0);
        run_txn("nack_addr", 16'hFFFF, 3'b011, 0);
        run_txn("start_busy", 16'h5A3C, 3'b111, 10);

        // Reset in the middle of the second byte
        ack_en = 3'b111;
        @(negedge clk);
        ctrl.data_in = 16'hABCD;
        ctrl.start   = 1'b1;
        @(negedge clk);
        ctrl.start = 1'b0;
        repeat (56 * CLK_DIV - 2) @(negedge clk);
        d0 = done_count;
        reset = 1'b0;
        @(negedge clk);
        check("midreset sclk", 32'(sclk), 32'd1);
        check("midreset sdin", 32'(sdin_bus), 32'd1);
        check("midreset busy", 32'(ctrl.busy), 32'd0);
        check("midreset done", 32'(ctrl.done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset no_done", done_count - d0, 32'd0);
        $display("txn midreset sclk=%0b sdin=%0b busy=%0b", sclk, sdin_bus, ctrl.busy);
        run_txn("post_reset", 16'h7E81, 3'b111, 0);

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("rand%0d", i), 16'($urandom), 3'($urandom_range(0, 7)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
